ingress_sched: RTL
==================

INGRESS_SCHED -- requirements
Module: ingress_sched

Interface
REQ-001 Parameter AGE_W, default 6, width of each per-port starvation age counter.
REQ-002 Parameter AGE_LIMIT, default 16, age at which a waiting port is promoted to starved class.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 arst_n  in  1  reset, asynchronous, active-low.
REQ-005 frame_exist  in  4  per-port complete frame present in PHY FIFO; synchronous to clk.
REQ-006 fifo_half  in  4  per-port half-full flag; write-clock domain, asynchronous to clk.
REQ-007 fifo_afull  in  4  per-port almost-full flag; write-clock domain, asynchronous to clk.
REQ-008 sched_en  in  1  downstream ready (header FIFO not full and body FIFO not almost full).
REQ-009 grant_valid  out  1  grant_id valid, awaiting acknowledge.
REQ-010 grant_id  out  2  selected PHY port.
REQ-011 grant_ack  in  1  decoder accepted grant and started reading the port.
REQ-012 frame_done  in  1  one-cycle pulse, decoder finished the granted frame.
REQ-013 busy  out  1  a granted frame is in progress.
REQ-014 starved  out  4  per-port flag, age >= AGE_LIMIT.

Function
REQ-015 fifo_half and fifo_afull SHALL each pass through a 2-FF synchronizer before use; 2-cycle sync latency.
REQ-016 A port SHALL be eligible only when frame_exist[p]=1; half/afull without frame_exist SHALL not qualify.
REQ-017 Priority classes, highest first: starved (age>=AGE_LIMIT), afull_sync, half_sync, frame_exist.
REQ-018 Within the highest non-empty class, selection SHALL be round-robin starting at rr_ptr, searching rr_ptr, rr_ptr+1, ... mod 4.
REQ-019 State machine SHALL have states IDLE, ARB, GRANT, BUSY.
REQ-020 IDLE: if sched_en=1 and any frame_exist=1 -> ARB; else stay.
REQ-021 ARB: register winner into grant_id, assert grant_valid -> GRANT; if no port eligible in ARB (exist dropped) -> IDLE with grant_valid=0.
REQ-022 Latency from IDLE sampling sched_en&exist to grant_valid=1 SHALL be 2 cycles.
REQ-023 GRANT: grant_valid and grant_id SHALL hold stable until grant_ack=1, regardless of sched_en or input changes.
REQ-024 On grant_ack in GRANT: grant_valid deasserts next cycle, busy=1, -> BUSY; rr_ptr <= grant_id+1 mod 4.
REQ-025 On grant_ack: granted port age <= 0; each other port with frame_exist=1 age <= age+1 saturating at 2^AGE_W-1; ports with frame_exist=0 age <= 0.
REQ-026 BUSY: on frame_done=1 -> IDLE, busy=0 next cycle; grant_id SHALL retain last value.
REQ-027 grant_ack outside GRANT and frame_done outside BUSY SHALL be ignored.
REQ-028 grant_ack and frame_done in the same GRANT cycle: only grant_ack acted on (-> BUSY).
REQ-029 starved[p] SHALL be a registered compare of age[p] >= AGE_LIMIT.
REQ-030 Unreachable state encoding SHALL return to IDLE next cycle with grant_valid=0, busy=0.

Reset
REQ-031 While arst_n=0: state IDLE, grant_valid=0, grant_id=0, busy=0, starved=0, rr_ptr=0, all ages 0, synchronizer flops 0.
REQ-032 Reset assertion mid-GRANT or mid-BUSY SHALL abort immediately to reset values; no grant replayed after release.
REQ-033 First grant after reset release SHALL require sched_en=1 sampled in IDLE.

Verification
REQ-034 exist=4'b0110, half=afull=0, sched_en=1 from reset -> grant_id=1 after 2 cycles; ack, done; next grant_id=2.
REQ-035 exist=4'b1111, afull=4'b1000 held >=2 cycles -> grant_id=3 despite rr_ptr=0; half=4'b0100 afull=0 -> grant_id=2.
REQ-036 AGE_LIMIT=2, exist=4'b1001, afull=4'b0001 held constant -> port 0 granted twice, then port 3 (starved[3]=1) granted third.
REQ-037 grant_valid=1, sched_en dropped to 0 and exist to 0 before ack -> grant_id unchanged until ack; ack -> busy=1.
REQ-038 arst_n pulsed low in BUSY -> busy=0, grant_valid=0, ages 0; no grant until sched_en=1 and exist!=0.
REQ-039 Spurious frame_done in IDLE and grant_ack in BUSY -> no state, rr_ptr or age change.

Source files
------------

// File: rtl/ingress_sched_if.sv
// Grant handshake between the ingress scheduler and the frame decoder.
// Scheduler offers grant_valid/grant_id; decoder answers with grant_ack and later frame_done.
interface ingress_sched_if;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       grant_ack;
    logic       frame_done;
    logic       busy;

    modport master (
        output grant_valid,
        output grant_id,
        output busy,
        input  grant_ack,
        input  frame_done
    );

    modport slave (
        input  grant_valid,
        input  grant_id,
        input  busy,
        output grant_ack,
        output frame_done
    );
endinterface

// File: rtl/ingress_sched.sv
// 4-port ingress arbiter (starved > afull > half > exist, round-robin in class); grant 2 cycles after IDLE sees sched_en.
// Backpressure: no arbitration while sched_en=0; a posted grant holds until grant_ack, then waits for frame_done.
module ingress_sched #(
    parameter int AGE_W     = 6,
    parameter int AGE_LIMIT = 16
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [3:0]      frame_exist,
    input  logic [3:0]      fifo_half,
    input  logic [3:0]      fifo_afull,
    input  logic            sched_en,
    output logic [3:0]      starved,
    ingress_sched_if.master gnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        GRANT = 3'd2,
        BUSY  = 3'd3
    } state_t;

    localparam logic [AGE_W:0]   LIMIT_C = (AGE_W+1)'(AGE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    state_t           state_q, state_d;
    logic             grant_valid_q, grant_valid_d;
    logic [1:0]       grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0] age_q [4];
    logic [AGE_W-1:0] age_d [4];
    logic [3:0]       starved_q, starved_d;
    logic [3:0]       half_meta_q, half_meta_d, half_sync_q, half_sync_d;
    logic [3:0]       afull_meta_q, afull_meta_d, afull_sync_q, afull_sync_d;

    logic [3:0]       win_cls;
    logic             win_hit;
    logic [1:0]       win_id;
    logic [1:0]       win_idx;

    // Highest non-empty class among ports that actually hold a frame.
    always_comb begin
        win_cls = frame_exist & starved_q;
        if (win_cls == 4'b0) win_cls = frame_exist & afull_sync_q;
        if (win_cls == 4'b0) win_cls = frame_exist & half_sync_q;
        if (win_cls == 4'b0) win_cls = frame_exist;
        win_hit = 1'b0;
        win_id  = rr_ptr_q;
        win_idx = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            win_idx = rr_ptr_q + 2'(i);
            if (!win_hit && win_cls[win_idx]) begin
                win_hit = 1'b1;
                win_id  = win_idx;
            end
        end
    end

    always_comb begin
        half_meta_d   = fifo_half;
        half_sync_d   = half_meta_q;
        afull_meta_d  = fifo_afull;
        afull_sync_d  = afull_meta_q;
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        busy_d        = busy_q;
        rr_ptr_d      = rr_ptr_q;
        for (int p = 0; p < 4; p++) age_d[p] = age_q[p];

        case (state_q)
            IDLE: begin
                if (sched_en && (|frame_exist)) state_d = ARB;
            end
            ARB: begin
                if (win_hit) begin
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    state_d       = GRANT;
                end else begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            GRANT: begin
                // frame_done in this cycle is deliberately ignored; ack wins.
                if (gnt.grant_ack) begin
                    grant_valid_d = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = BUSY;
                    rr_ptr_d      = grant_id_q + 2'd1;
                    for (int p = 0; p < 4; p++) begin
                        if (2'(p) == grant_id_q)      age_d[p] = '0;
                        else if (!frame_exist[p])     age_d[p] = '0;
                        else if (age_q[p] != AGE_MAX) age_d[p] = age_q[p] + AGE_W'(1);
                    end
                end
            end
            BUSY: begin
                if (gnt.frame_done) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_valid_d = 1'b0;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
        endcase

        for (int p = 0; p < 4; p++) starved_d[p] = ({1'b0, age_d[p]} >= LIMIT_C);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= 2'd0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= 2'd0;
            starved_q     <= 4'b0;
            half_meta_q   <= 4'b0;
            half_sync_q   <= 4'b0;
            afull_meta_q  <= 4'b0;
            afull_sync_q  <= 4'b0;
            for (int p = 0; p < 4; p++) age_q[p] <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            starved_q     <= starved_d;
            half_meta_q   <= half_meta_d;
            half_sync_q   <= half_sync_d;
            afull_meta_q  <= afull_meta_d;
            afull_sync_q  <= afull_sync_d;
            for (int p = 0; p < 4; p++) age_q[p] <= age_d[p];
        end
    end

    assign gnt.grant_valid = grant_valid_q;
    assign gnt.grant_id    = grant_id_q;
    assign gnt.busy        = busy_q;
    assign starved         = starved_q;

endmodule
